// File: rtl/cfg_pkg.sv
// cfg_pkg: shared definitions for the config-bank write scheduler.
//   - register index constants of the 16 x 8-bit system config bank
//   - restore sequencer state encoding
//   - bank write-request record {we, addr, dat}
package cfg_pkg;

  localparam int CFG_AW = 4;

  localparam logic [CFG_AW-1:0] MAP_IDX = 4'd0;
  localparam logic [CFG_AW-1:0] PRG_MSK = 4'd1;
  localparam logic [CFG_AW-1:0] CHR_MSK = 4'd2;
  localparam logic [CFG_AW-1:0] VOL     = 4'd3;
  localparam logic [CFG_AW-1:0] MAP_CFG = 4'd4;
  localparam logic [CFG_AW-1:0] SS_SAVE = 4'd5;
  localparam logic [CFG_AW-1:0] SS_LOAD = 4'd6;
  localparam logic [CFG_AW-1:0] CTRL    = 4'd7;
  localparam logic [CFG_AW-1:0] SS_MENU = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } rs_state_e;

  typedef struct packed {
    logic              we;
    logic [CFG_AW-1:0] addr;
    logic [7:0]        dat;
  } cfg_wr_req_t;

endpackage

// File: rtl/cfg_seq_idx.sv
// cfg_seq_idx: maps the restore step count to the register index to restore.
// Order is 0..NREG-1 ascending with CTRL_IDX removed, then CTRL_IDX last, so
// the unlock bit is only re-armed once every other register is back.
//   count  in   AW  restore step (0..NREG-1)
//   idx    out  AW  register index for that step
module cfg_seq_idx #(
  parameter int NREG     = 16,
  parameter int AW       = 4,
  parameter int CTRL_IDX = 7
) (
  input  logic [AW-1:0] count,
  output logic [AW-1:0] idx
);

  always_comb begin
    if (count == AW'(NREG - 1))
      idx = AW'(CTRL_IDX);
    else if (count >= AW'(CTRL_IDX))
      idx = count + AW'(1);
    else
      idx = count;
  end

endmodule

// File: rtl/cfg_wr_sched.sv
// cfg_wr_sched: shares the config bank write port between host writes,
// save-state engine single writes and the bulk-restore sequencer.
// Priority each cycle: host > restore > engine. All outputs registered.
// Optional macro CFG_WR_SCHED_CHK_EN adds an XOR checksum over restored bytes
// compared against rs_chk at the end of a restore (sticky err).
//   clk, rst_n                     clock, async active-low reset
//   host_we/host_addr/host_dat     host write, never stalled
//   ss_req/ss_addr/ss_dat/ss_ack   engine write request / accept pulse
//   rs_start                       restore start pulse
//   rs_rd_addr/rs_rd_dat           restore source read (1-cycle latency)
//   rs_chk                         expected restore checksum
//   cfg_we/cfg_addr/cfg_dat        bank write port
//   busy/done/err                  restore status
//
// state   | meaning
// IDLE    | no restore; engine writes may be served
// RD      | source read address presented for current step
// WR      | source byte captured; write issued unless host blocks
// FIN     | done pulse; busy drops next cycle
module cfg_wr_sched
  import cfg_pkg::*;
#(
  parameter int NREG     = 16,
  parameter int AW       = 4,
  parameter int CTRL_IDX = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_dat,
  input  logic          ss_req,
  input  logic [AW-1:0] ss_addr,
  input  logic [7:0]    ss_dat,
  output logic          ss_ack,
  input  logic          rs_start,
  output logic [AW-1:0] rs_rd_addr,
  input  logic [7:0]    rs_rd_dat,
  input  logic [7:0]    rs_chk,
  output logic          cfg_we,
  output logic [AW-1:0] cfg_addr,
  output logic [7:0]    cfg_dat,
  output logic          busy,
  output logic          done,
  output logic          err
);

  rs_state_e     state, state_d;
  logic [AW-1:0] count, count_d, idx_d;
  logic          wr_first;
  logic [7:0]    cap_dat, rs_byte;
  logic          rs_go, rs_wr, ss_go, last;
  cfg_wr_req_t   req;

  cfg_seq_idx #(.NREG(NREG), .AW(AW), .CTRL_IDX(CTRL_IDX)) u_seq_idx (
    .count (count_d),
    .idx   (idx_d)
  );

  // Source data is only guaranteed in the first WR cycle; a blocked write
  // reuses the byte captured then.
  assign rs_byte = wr_first ? rs_rd_dat : cap_dat;
  assign rs_go   = (state == ST_IDLE) && rs_start;
  assign rs_wr   = (state == ST_WR) && !host_we;
  assign last    = (count == AW'(NREG - 1));
  // ss_ack blocks re-acceptance while the engine still holds ss_req.
  assign ss_go   = ss_req && !ss_ack && (state == ST_IDLE) && !host_we && !rs_start;

  always_comb begin
    state_d = state;
    count_d = count;
    unique case (state)
      ST_IDLE: if (rs_start) begin
        state_d = ST_RD;
        count_d = '0;
      end
      ST_RD:   state_d = ST_WR;
      ST_WR:   if (rs_wr) begin
        if (last) state_d = ST_FIN;
        else begin
          state_d = ST_RD;
          count_d = count + AW'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req = '0;
    if (host_we)    req = '{1'b1, host_addr, host_dat};
    else if (rs_wr) req = '{1'b1, rs_rd_addr, rs_byte};
    else if (ss_go) req = '{1'b1, ss_addr, ss_dat};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      wr_first   <= 1'b0;
      cap_dat    <= '0;
      rs_rd_addr <= '0;
      cfg_we     <= 1'b0;
      cfg_addr   <= '0;
      cfg_dat    <= '0;
      ss_ack     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      wr_first <= (state_d == ST_WR) && (state != ST_WR);
      if (state == ST_WR) cap_dat <= rs_byte;
      if (state_d == ST_RD) rs_rd_addr <= idx_d;
      cfg_we <= req.we;
      if (req.we) begin
        cfg_addr <= req.addr;
        cfg_dat  <= req.dat;
      end
      ss_ack <= ss_go;
      busy   <= (state_d != ST_IDLE);
      done   <= (state_d == ST_FIN);
    end
  end

`ifdef CFG_WR_SCHED_CHK_EN
  logic [7:0] chk_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_acc <= '0;
      err     <= 1'b0;
    end else begin
      if (rs_go)      chk_acc <= '0;
      else if (rs_wr) chk_acc <= chk_acc ^ rs_byte;
      if (rs_go) err <= 1'b0;
      else if ((state == ST_FIN) && (chk_acc != rs_chk)) err <= 1'b1;
    end
  end
`else
  logic unused_chk;
  assign unused_chk = ^rs_chk;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_wr_sched.sv
// tb_cfg_wr_sched: directed plus random stimulus for cfg_wr_sched. The driver
// predicts each bank write, ack, done, busy window and err from the scheduling
// rules and queues them; an independent monitor compares on the falling edge.
module tb_cfg_wr_sched;

  logic       clk, rst_n;
  logic       host_we, ss_req, ss_ack, rs_start, cfg_we, busy, done, err;
  logic [3:0] host_addr, ss_addr, rs_rd_addr, cfg_addr;
  logic [7:0] host_dat, ss_dat, rs_rd_dat, rs_chk, cfg_dat;

  cfg_wr_sched dut (
    .clk(clk), .rst_n(rst_n),
    .host_we(host_we), .host_addr(host_addr), .host_dat(host_dat),
    .ss_req(ss_req), .ss_addr(ss_addr), .ss_dat(ss_dat), .ss_ack(ss_ack),
    .rs_start(rs_start), .rs_rd_addr(rs_rd_addr), .rs_rd_dat(rs_rd_dat),
    .rs_chk(rs_chk), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_dat(cfg_dat),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {int c; logic [3:0] a; logic [7:0] d;} wr_t;
  typedef struct {int c; bit v;} ev_t;

  wr_t  wq[$];
  int   aq[$];
  int   dq[$];
  ev_t  eq[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_c = 0, done_cyc = -1;
  logic [3:0] seq[16];
  logic [7:0] src[16], src_next[16], mbank[16], dut_bank[16];
  logic [7:0] cur_chk = 8'h00, chk_next = 8'h00;
  bit   rs_active = 0, ss_pend = 0, err_exp = 0;
  int   rs_k = 0, rs_next = 0, b_lo = 0, b_hi = -1, ack_c = -1;
  logic [7:0] acc = 8'h00;
  logic [3:0] ss_a = 4'd0, addr_prev = 4'd0;
  logic [7:0] ss_d = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] xor_all(input logic [7:0] m[16]);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 16; i++) x ^= m[i];
    return x;
  endfunction

  function automatic bit m_busy(input int c);
    return (c >= b_lo) && (c <= b_hi);
  endfunction

  // monitor
  initial forever begin
    bit e_we, e_ack, e_done;
    @(negedge clk);
    e_we = (wq.size() > 0) && (wq[0].c == cyc);
    chk("cfg_we", int'(cfg_we), int'(e_we));
    if (e_we) begin
      if (cfg_we) begin
        chk("cfg_addr", int'(cfg_addr), int'(wq[0].a));
        chk("cfg_dat", int'(cfg_dat), int'(wq[0].d));
      end
      void'(wq.pop_front());
    end
    if (cfg_we) dut_bank[cfg_addr] = cfg_dat;
    e_ack = (aq.size() > 0) && (aq[0] == cyc);
    chk("ss_ack", int'(ss_ack), int'(e_ack));
    if (e_ack) void'(aq.pop_front());
    e_done = (dq.size() > 0) && (dq[0] == cyc);
    chk("done", int'(done), int'(e_done));
    if (e_done) void'(dq.pop_front());
    if (done) done_cyc = cyc;
    chk("busy", int'(busy), int'(m_busy(cyc)));
    while (eq.size() > 0 && eq[0].c <= cyc) begin
      err_exp = eq[0].v;
      void'(eq.pop_front());
    end
    chk("err", int'(err), int'(err_exp));
  end

  // One cycle of stimulus plus the reference prediction for that cycle.
  task automatic step(input bit h_we, input logic [3:0] h_a, input logic [7:0] h_d,
                      input bit rs, input bit ss_new, input logic [3:0] s_a,
                      input logic [7:0] s_d, input bit do_rst);
    int c;
    bit busy_c, ss_go;
    logic [3:0] a;
    @(negedge clk); #1;
    c = cyc;
    last_c = c;
    // source memory: data valid only in the cycle after the read address
    rs_rd_dat = (rs_active && c == rs_next) ? src[addr_prev] : 8'($urandom);
    addr_prev = rs_rd_addr;
    if (do_rst) begin
      rst_n = 1'b0; host_we = 1'b0; rs_start = 1'b0; ss_req = 1'b0;
      wq.delete(); aq.delete(); dq.delete(); eq.delete();
      eq.push_back('{c + 1, 1'b0});
      rs_active = 0; b_lo = 0; b_hi = -1; ss_pend = 0; ack_c = -1;
      #1;
      chk("rst_cfg_we", int'(cfg_we), 0);
      chk("rst_cfg_addr", int'(cfg_addr), 0);
      chk("rst_cfg_dat", int'(cfg_dat), 0);
      chk("rst_ss_ack", int'(ss_ack), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_rd_addr", int'(rs_rd_addr), 0);
      return;
    end
    rst_n = 1'b1;
    host_we = h_we; host_addr = h_a; host_dat = h_d;
    rs_start = rs;
    rs_chk = cur_chk;
    if (ss_new && !ss_pend) begin
      ss_pend = 1; ss_a = s_a; ss_d = s_d;
    end
    ss_req = ss_pend; ss_addr = ss_a; ss_dat = ss_d;

    busy_c = m_busy(c);
    if (h_we) begin
      wq.push_back('{c + 1, h_a, h_d});
      mbank[h_a] = h_d;
    end
    if (rs_active && c >= rs_next && !h_we) begin
      a = seq[rs_k];
      wq.push_back('{c + 1, a, src[a]});
      mbank[a] = src[a];
      acc ^= src[a];
      rs_k++;
      rs_next = c + 2;
      if (rs_k == 16) begin
        rs_active = 0;
        dq.push_back(c + 1);
        b_hi = c + 1;
`ifdef CFG_WR_SCHED_CHK_EN
        eq.push_back('{c + 2, acc != cur_chk});
`endif
      end
    end
    if (rs && !busy_c) begin
      src = src_next;
      cur_chk = chk_next;
      rs_chk = cur_chk;
      rs_active = 1; rs_k = 0; rs_next = c + 2;
      b_lo = c + 1; b_hi = 32'h3fff_ffff; acc = 8'h00;
`ifdef CFG_WR_SCHED_CHK_EN
      eq.push_back('{c + 1, 1'b0});
`endif
    end
    ss_go = ss_pend && !busy_c && !h_we && !rs && (c != ack_c);
    if (ss_go) begin
      wq.push_back('{c + 1, ss_a, ss_d});
      mbank[ss_a] = ss_d;
      aq.push_back(c + 1);
      ack_c = c + 1;
    end
    if (c == ack_c) ss_pend = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 8'd0, 0, 0, 4'd0, 8'd0, 0);
  endtask

  task automatic host(input logic [3:0] a, input logic [7:0] d);
    step(1, a, d, 0, 0, 4'd0, 8'd0, 0);
  endtask

  task automatic start_rs();
    step(0, 4'd0, 8'd0, 1, 0, 4'd0, 8'd0, 0);
  endtask

  initial begin
    int s, k;
    rst_n = 1'b0; host_we = 1'b0; host_addr = '0; host_dat = '0;
    ss_req = 1'b0; ss_addr = '0; ss_dat = '0; rs_start = 1'b0;
    rs_rd_dat = '0; rs_chk = '0;
    k = 0;
    for (int i = 0; i < 16; i++) if (i != 7) begin seq[k] = 4'(i); k++; end
    seq[15] = 4'd7;
    for (int i = 0; i < 16; i++) begin
      mbank[i] = 8'h00; dut_bank[i] = 8'h00;
      src[i] = 8'(8'h10 + i); src_next[i] = 8'(8'h10 + i);
    end

    step(0, 4'd0, 8'd0, 0, 0, 4'd0, 8'd0, 1);
    step(0, 4'd0, 8'd0, 0, 0, 4'd0, 8'd0, 1);
    idle(2);

    host(4'd3, 8'h80);
    idle(1);
    host(4'd0, 8'hA0);
    host(4'd1, 8'hA1);
    idle(2);
    step(0, 4'd0, 8'd0, 0, 1, 4'd5, 8'h41, 0);
    idle(3);
    step(1, 4'd2, 8'h22, 0, 1, 4'd5, 8'h41, 0);
    idle(3);

    chk_next = 8'h00;
    start_rs();
    s = last_c;
    idle(40);
    chk("done_latency", done_cyc - s, 33);
    chk("bank7_last", int'(dut_bank[7]), 8'h17);

    chk_next = 8'h5A;
    start_rs();
    s = last_c;
    idle(9);
    host(4'd9, 8'hFF);
    idle(30);
    chk("done_latency_blocked", done_cyc - s, 34);
    chk("bank9_restored", int'(dut_bank[9]), 8'h19);
    idle(2);

    chk_next = 8'h00;
    done_cyc = -1;
    start_rs();
    idle(9);
    step(0, 4'd0, 8'd0, 0, 0, 4'd0, 8'd0, 1);
    step(0, 4'd0, 8'd0, 0, 0, 4'd0, 8'd0, 1);
    idle(3);
    chk("no_done_after_rst", done_cyc, -1);
    step(0, 4'd0, 8'd0, 1, 1, 4'd5, 8'h33, 0);
    s = last_c;
    idle(40);
    chk("done_latency_fresh", done_cyc - s, 33);

    for (int n = 0; n < 4000; n++) begin
      bit h, rs, sn, rr;
      h  = ($urandom_range(0, 99) < 20);
      rs = ($urandom_range(0, 99) < 3);
      sn = ($urandom_range(0, 99) < 25);
      rr = ($urandom_range(0, 999) < 3);
      if (rs) begin
        for (int i = 0; i < 16; i++) src_next[i] = 8'($urandom);
        chk_next = ($urandom_range(0, 1) == 1) ? xor_all(src_next) : 8'($urandom);
      end
      step(h, 4'($urandom), 8'($urandom), rs, sn, 4'($urandom), 8'($urandom), rr);
    end
    idle(50);
    chk("wq_drained", wq.size(), 0);
    chk("aq_drained", aq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    for (int i = 0; i < 16; i++) chk($sformatf("bank%0d", i), int'(dut_bank[i]), int'(mbank[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
